// File: rtl/nn_pool_pkg.sv
// Shared types and constants for the grid pooling front end.
// Holds the FSM state enum, gray width, RGB channel slices and accumulator sizing.
package nn_pool_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam int GRAY_W = 10;
  localparam int RGB_W  = 30;
  localparam int R_MSB  = 29;
  localparam int R_LSB  = 20;
  localparam int G_MSB  = 19;
  localparam int G_LSB  = 10;
  localparam int B_MSB  = 9;
  localparam int B_LSB  = 0;

  // A cell holds 2^(2*cell_log2) gray samples, so the sum needs that many extra bits.
  function automatic int acc_w(input int cell_log2);
    return GRAY_W + 2 * cell_log2;
  endfunction

endpackage

// File: rtl/nn_rgb2gray.sv
// Registered RGB -> gray converter: gray = (R + 2G + B) >> 2, one cycle latency.
// i_flush drops the beat being captured so a restart never leaks an old pixel.
module nn_rgb2gray
  import nn_pool_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RGB_W-1:0]  i_rgb,
  input  logic              i_valid,
  input  logic              i_flush,
  output logic [GRAY_W-1:0] o_gray,
  output logic              o_valid
);

  logic [GRAY_W+1:0] w_sum;
  logic [GRAY_W-1:0] r_gray;
  logic              r_valid;

  assign w_sum = {2'b00, i_rgb[R_MSB:R_LSB]}
               + {1'b0, i_rgb[G_MSB:G_LSB], 1'b0}
               + {2'b00, i_rgb[B_MSB:B_LSB]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gray  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid && !i_flush;
      if (i_valid) r_gray <= w_sum[GRAY_W+1:2];
    end
  end

  assign o_gray  = r_gray;
  assign o_valid = r_valid;

endmodule

// File: rtl/nn_grid_pooler.sv
// Pools a per-frame square ROI of the RGB pixel stream into GRID x GRID 8-bit cells.
// Build option NN_POOL_MAX_EN selects max pooling; otherwise cells are block means.
module nn_grid_pooler
  import nn_pool_pkg::*;
#(
  parameter int IMG_W     = 1280,
  parameter int IMG_H     = 720,
  parameter int GRID      = 28,
  parameter int CELL_LOG2 = 4
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic [RGB_W-1:0]             rgb10,
  input  logic                         dat_valid,
  input  logic                         frame_start,
  input  logic                         frame_end,
  input  logic [11:0]                  roi_x,
  input  logic [11:0]                  roi_y,
  output logic [7:0]                   cell_data,
  output logic [$clog2(GRID*GRID)-1:0] cell_idx,
  output logic                         cell_valid,
  output logic                         grid_done,
  output logic                         frame_err
);

  localparam int XW     = 12;
  localparam int NCELL  = GRID * GRID;
  localparam int IDX_W  = $clog2(NCELL);
  localparam int COL_W  = (GRID > 1) ? $clog2(GRID) : 1;
  localparam int SPAN_I = GRID << CELL_LOG2;
  localparam logic [XW:0]      SPAN     = SPAN_I[XW:0];
  localparam logic [XW-1:0]    X_LAST   = XW'(IMG_W - 1);
  localparam logic [XW-1:0]    Y_LAST   = XW'(IMG_H - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCELL - 1);
`ifdef NN_POOL_MAX_EN
  localparam int ACC_W = GRAY_W;
`else
  localparam int ACC_W = acc_w(CELL_LOG2);
`endif

  state_t            r_state, w_next;
  logic [XW-1:0]     r_px_x, r_px_y, r_roi_x, r_roi_y;
  logic              r_full;
  logic              w_pix_en, w_err, w_take, w_overrun;
  logic [XW:0]       w_rel_x, w_rel_y;
  logic              w_in_roi, w_cell_last;
  logic [COL_W-1:0]  r_s1_col;
  logic              r_s1_last;
  logic [GRAY_W-1:0] w_gray;
  logic              w_gray_vld;
  logic              w_s2, w_emit_last;
  logic [ACC_W-1:0]  r_acc [GRID];
  logic [ACC_W-1:0]  w_acc_cur, w_acc_new;
  logic [IDX_W-1:0]  r_idx, r_cell_idx;
  logic [7:0]        r_cell_data;
  logic              r_cell_valid, r_grid_done, r_frame_err;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (frame_start) begin
      w_next = ACTIVE;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        ACTIVE: begin
          if (frame_end)                       w_next = IDLE;
          else if (w_emit_last || w_overrun)   w_next = DONE;
        end
        DONE:    if (frame_end) w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_pix_en = 1'b0;
    w_err    = 1'b0;
    if (r_state == ACTIVE && !frame_start) begin
      w_pix_en = dat_valid;
      w_err    = frame_end || (dat_valid && r_full);
    end
  end

  // r_full marks that the last pixel of the frame has been consumed; any further beat overruns.
  assign w_take    = w_pix_en && !r_full;
  assign w_overrun = w_pix_en && r_full;

  assign w_rel_x     = {1'b0, r_px_x} - {1'b0, r_roi_x};
  assign w_rel_y     = {1'b0, r_px_y} - {1'b0, r_roi_y};
  assign w_in_roi    = (r_px_x >= r_roi_x) && (r_px_y >= r_roi_y)
                    && (w_rel_x < SPAN) && (w_rel_y < SPAN);
  assign w_cell_last = (&w_rel_x[CELL_LOG2-1:0]) && (&w_rel_y[CELL_LOG2-1:0]);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_px_x    <= '0;
      r_px_y    <= '0;
      r_roi_x   <= '0;
      r_roi_y   <= '0;
      r_full    <= 1'b0;
      r_s1_col  <= '0;
      r_s1_last <= 1'b0;
    end else if (frame_start) begin
      r_px_x  <= '0;
      r_px_y  <= '0;
      r_roi_x <= roi_x;
      r_roi_y <= roi_y;
      r_full  <= 1'b0;
    end else if (w_take) begin
      r_s1_col  <= w_rel_x[CELL_LOG2 +: COL_W];
      r_s1_last <= w_cell_last;
      if (r_px_x == X_LAST) begin
        r_px_x <= '0;
        if (r_px_y == Y_LAST) begin
          r_px_y <= '0;
          r_full <= 1'b1;
        end else begin
          r_px_y <= r_px_y + 1'b1;
        end
      end else begin
        r_px_x <= r_px_x + 1'b1;
      end
    end
  end

  nn_rgb2gray u_rgb2gray (
    .clk     (Clk),
    .rst_n   (Rst_n),
    .i_rgb   (rgb10),
    .i_valid (w_take && w_in_roi),
    .i_flush (frame_start),
    .o_gray  (w_gray),
    .o_valid (w_gray_vld)
  );

  assign w_s2        = w_gray_vld && (r_state == ACTIVE) && !frame_start;
  assign w_emit_last = w_s2 && r_s1_last && (r_idx == IDX_LAST);
  assign w_acc_cur   = r_acc[r_s1_col];
`ifdef NN_POOL_MAX_EN
  assign w_acc_new = (w_gray > w_acc_cur) ? w_gray : w_acc_cur;
`else
  assign w_acc_new = w_acc_cur + ACC_W'(w_gray);
`endif

  // The top 8 bits of the accumulator are the mean (sum >> 2*CELL_LOG2+2) or max >> 2.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < GRID; i++) r_acc[i] <= '0;
      r_idx        <= '0;
      r_cell_idx   <= '0;
      r_cell_data  <= '0;
      r_cell_valid <= 1'b0;
      r_grid_done  <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_cell_valid <= 1'b0;
      r_grid_done  <= 1'b0;
      r_frame_err  <= w_err;
      if (frame_start) begin
        for (int i = 0; i < GRID; i++) r_acc[i] <= '0;
        r_idx <= '0;
      end else if (w_s2) begin
        if (r_s1_last) begin
          r_acc[r_s1_col] <= '0;
          r_cell_valid    <= 1'b1;
          r_cell_data     <= w_acc_new[ACC_W-1 -: 8];
          r_cell_idx      <= r_idx;
          r_grid_done     <= (r_idx == IDX_LAST);
          r_idx           <= r_idx + 1'b1;
        end else begin
          r_acc[r_s1_col] <= w_acc_new;
        end
      end
    end
  end

  assign cell_data  = r_cell_data;
  assign cell_idx   = r_cell_idx;
  assign cell_valid = r_cell_valid;
  assign grid_done  = r_grid_done;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_nn_grid_pooler.sv
// Directed bench for nn_grid_pooler on an 8x8 image, 2x2 grid of 4x4 cells.
// Expected cell values are hand-computed; NN_POOL_MAX_EN switches them to max pooling.
module tb_nn_grid_pooler;

  localparam int IMG_W     = 8;
  localparam int IMG_H     = 8;
  localparam int GRID      = 2;
  localparam int CELL_LOG2 = 2;
  localparam int IDX_W     = $clog2(GRID * GRID);

`ifdef NN_POOL_MAX_EN
  localparam logic [7:0] C0 = 8'd27;
  localparam logic [7:0] C1 = 8'd31;
  localparam logic [7:0] C2 = 8'd59;
  localparam logic [7:0] C3 = 8'd63;
`else
  localparam logic [7:0] C0 = 8'd13;
  localparam logic [7:0] C1 = 8'd17;
  localparam logic [7:0] C2 = 8'd45;
  localparam logic [7:0] C3 = 8'd49;
`endif
  localparam logic [7:0] CF = 8'd255;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b1;
  logic [29:0]      rgb10 = '0;
  logic             dat_valid = 1'b0;
  logic             frame_start = 1'b0;
  logic             frame_end = 1'b0;
  logic [11:0]      roi_x = '0;
  logic [11:0]      roi_y = '0;
  logic [7:0]       cell_data;
  logic [IDX_W-1:0] cell_idx;
  logic             cell_valid;
  logic             grid_done;
  logic             frame_err;

  typedef struct {
    logic [7:0]       data;
    logic [IDX_W-1:0] idx;
    logic             done;
    int               cyc;
  } beat_t;

  beat_t beats[$];
  int cyc = 0;
  int errPulses = 0;
  int donePulses = 0;
  int nPass = 0;
  int nChecks = 0;
  int pix27Cyc = 0;

  nn_grid_pooler #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .GRID(GRID), .CELL_LOG2(CELL_LOG2)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .rgb10(rgb10), .dat_valid(dat_valid),
    .frame_start(frame_start), .frame_end(frame_end), .roi_x(roi_x), .roi_y(roi_y),
    .cell_data(cell_data), .cell_idx(cell_idx), .cell_valid(cell_valid),
    .grid_done(grid_done), .frame_err(frame_err)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin : monitor
    beat_t b;
    if (cell_valid) begin
      b.data = cell_data;
      b.idx  = cell_idx;
      b.done = grid_done;
      b.cyc  = cyc;
      beats.push_back(b);
    end
    if (frame_err) errPulses++;
    if (grid_done) donePulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) begin
      nPass++;
    end else begin
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [29:0] rgb, input logic v, input logic fs, input logic fe);
    @(posedge Clk);
    #1;
    rgb10       = rgb;
    dat_valid   = v;
    frame_start = fs;
    frame_end   = fe;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(30'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Pattern 0: flat 1020; pattern 1: 4*(x + 8y) = 4*p on every channel.
  task automatic sendFrame(input int pattern, input int nPix, input int rx, input int ry);
    logic [9:0] v;
    roi_x = 12'(rx);
    roi_y = 12'(ry);
    applyStimulus(30'd0, 1'b0, 1'b1, 1'b0);
    for (int p = 0; p < nPix; p++) begin
      v = (pattern == 0) ? 10'd1020 : 10'(4 * p);
      applyStimulus({v, v, v}, 1'b1, 1'b0, 1'b0);
      if (p == 27) pix27Cyc = cyc;
    end
  endtask

  task automatic endFrame();
    idle(4);
    applyStimulus(30'd0, 1'b0, 1'b0, 1'b1);
    idle(3);
  endtask

  task automatic checkGrid(input string tag, input int nExp,
                           input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input int expErr, input int expDone);
    logic [7:0] dv [4];
    dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
    checkOutput({tag, ".count"}, beats.size(), nExp);
    for (int i = 0; i < nExp && i < beats.size(); i++) begin
      checkOutput($sformatf("%s.data%0d", tag, i), beats[i].data, dv[i]);
      checkOutput($sformatf("%s.idx%0d", tag, i), beats[i].idx, i);
      checkOutput($sformatf("%s.done%0d", tag, i), beats[i].done, (i == 3));
    end
    checkOutput({tag, ".frame_err"}, errPulses, expErr);
    checkOutput({tag, ".grid_done"}, donePulses, expDone);
    beats.delete();
    errPulses  = 0;
    donePulses = 0;
  endtask

  initial begin
    $display("[TB] nn_grid_pooler bench start");
    #1 Rst_n = 1'b0;
    #11;
    checkOutput("rst.cell_valid", cell_valid, 0);
    checkOutput("rst.cell_data", cell_data, 0);
    checkOutput("rst.cell_idx", cell_idx, 0);
    checkOutput("rst.grid_done", grid_done, 0);
    checkOutput("rst.frame_err", frame_err, 0);
    Rst_n = 1'b1;
    idle(2);

    sendFrame(0, 64, 0, 0);
    endFrame();
    if (beats.size() > 0) checkOutput("flat.latency", beats[0].cyc - pix27Cyc, 2);
    checkGrid("flat", 4, CF, CF, CF, CF, 0, 1);

    sendFrame(1, 64, 0, 0);
    endFrame();
    checkGrid("ramp", 4, C0, C1, C2, C3, 0, 1);

    sendFrame(1, 64, 4, 4);
    endFrame();
    checkGrid("roi44", 1, C3, 8'd0, 8'd0, 8'd0, 1, 0);

    sendFrame(1, 40, 0, 0);
    endFrame();
    checkGrid("short", 2, C0, C1, 8'd0, 8'd0, 1, 0);
    sendFrame(1, 64, 0, 0);
    endFrame();
    checkGrid("after_short", 4, C0, C1, C2, C3, 0, 1);

    sendFrame(1, 20, 0, 0);
    sendFrame(1, 64, 0, 0);
    endFrame();
    checkGrid("restart20", 4, C0, C1, C2, C3, 0, 1);

    // Restart lands while the last pixel of cell 0 is in the gray stage; it must be dropped.
    sendFrame(1, 28, 0, 0);
    sendFrame(1, 64, 0, 0);
    endFrame();
    checkGrid("restart28", 4, C0, C1, C2, C3, 0, 1);

    sendFrame(1, 65, 4, 4);
    idle(4);
    checkGrid("overrun", 1, C3, 8'd0, 8'd0, 8'd0, 1, 0);
    applyStimulus(30'd0, 1'b0, 1'b0, 1'b1);
    idle(3);
    checkOutput("overrun.end_in_done", errPulses, 0);
    errPulses = 0;

    sendFrame(1, 28, 0, 0);
    idle(1);
    @(posedge Clk);
    #2;
    checkOutput("prerst.cell_valid", cell_valid, 1);
    checkOutput("prerst.cell_data", cell_data, C0);
    Rst_n = 1'b0;
    #1;
    checkOutput("midrst.cell_valid", cell_valid, 0);
    checkOutput("midrst.cell_data", cell_data, 0);
    checkOutput("midrst.cell_idx", cell_idx, 0);
    checkOutput("midrst.grid_done", grid_done, 0);
    checkOutput("midrst.frame_err", frame_err, 0);
    idle(2);
    #2 Rst_n = 1'b1;
    beats.delete();
    errPulses  = 0;
    donePulses = 0;
    sendFrame(1, 64, 0, 0);
    endFrame();
    checkGrid("post_rst", 4, C0, C1, C2, C3, 0, 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
